// File: rtl/yo6530_pkg.sv
// yo6530_pkg: shared types, widths and decode helpers for the 6530 bus interface.
package yo6530_pkg;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 8;
   localparam int RAM_A_W = 6;
   localparam int IO_A_W  = 4;

   typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_RAM, SEL_IO} sel_t;
   typedef enum logic [1:0] {IDLE, WAIT, DRIVE, WHOLD} state_t;

   // The bit just above the RAM address field picks RAM versus I/O.
   function automatic sel_t decode_sel(input logic rs0, input logic io_bit);
      return rs0 ? SEL_ROM : (io_bit ? SEL_IO : SEL_RAM);
   endfunction

   function automatic logic [2:0] sel_onehot(input sel_t s);
      return {s == SEL_ROM, s == SEL_RAM, s == SEL_IO};
   endfunction

endpackage

// File: rtl/yo6530_phi2_sync.sv
// yo6530_phi2_sync: synchronises phi2 into clk and emits one-cycle rise/fall pulses.
module yo6530_phi2_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic phi2,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sr;
   logic                   q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
         q  <= 1'b0;
      end else begin
         sr <= {sr[SYNC_STAGES-2:0], phi2};
         q  <= sr[SYNC_STAGES-1];
      end
   end

   assign rise = sr[SYNC_STAGES-1] & ~q;
   assign fall = ~sr[SYNC_STAGES-1] & q;

endmodule

// File: rtl/yo6530_bus_if.sv
// yo6530_bus_if: 6502-side bus interface for the 6530 ROM/RAM/IO blocks.
// Define YO6530_BUS_CONFLICT_DET_EN to add the sticky bus_conflict output.
module yo6530_bus_if import yo6530_pkg::*; #(
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              phi2,
   input  logic              cs,
   input  logic              rw,
   input  logic              rs0,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              d_oe,
   output logic              rom_en,
   output logic              ram_en,
   output logic              io_en,
   output logic [ADDR_W-1:0] addr_q,
   output logic [DATA_W-1:0] wr_data,
   output logic              ram_we,
   output logic              io_we,
   input  logic              rom_oe,
   input  logic              ram_oe,
   input  logic              io_oe,
   input  logic [DATA_W-1:0] rom_do,
   input  logic [DATA_W-1:0] ram_do,
   input  logic [DATA_W-1:0] io_do
`ifdef YO6530_BUS_CONFLICT_DET_EN
   ,
   output logic              bus_conflict
`endif
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

   state_t            state;
   sel_t              sel, dec;
   logic [1:0]        cnt;
   logic              rise, fall, sel_oe;
   logic [DATA_W-1:0] sel_do;

   yo6530_phi2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .phi2 (phi2),
      .rise (rise),
      .fall (fall)
   );

   always_comb begin
      dec    = decode_sel(rs0, a[RAM_A_W]);
      sel_oe = sel == SEL_ROM ? rom_oe : sel == SEL_RAM ? ram_oe : sel == SEL_IO ? io_oe : 1'b0;
      sel_do = sel == SEL_ROM ? rom_do : sel == SEL_RAM ? ram_do : sel == SEL_IO ? io_do : '0;
   end

   // A rise always restarts the access, whatever state the FSM was in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         sel                     <= SEL_NONE;
         cnt                     <= '0;
         addr_q                  <= '0;
         wr_data                 <= '0;
         d_out                   <= '0;
         d_oe                    <= 1'b0;
         {rom_en, ram_en, io_en} <= '0;
         ram_we                  <= 1'b0;
         io_we                   <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         io_we  <= 1'b0;
         if (rise) begin
            d_oe  <= 1'b0;
            d_out <= '0;
            if (cs) begin
               state                   <= rw ? WAIT : WHOLD;
               sel                     <= dec;
               addr_q                  <= a;
               cnt                     <= '0;
               {rom_en, ram_en, io_en} <= sel_onehot(dec);
            end else begin
               state                   <= IDLE;
               {rom_en, ram_en, io_en} <= '0;
            end
         end else begin
            case (state)
               WAIT: begin
                  if (fall) begin
                     state                   <= IDLE;
                     {rom_en, ram_en, io_en} <= '0;
                  end else if (cnt == LAT_LAST) begin
                     state <= DRIVE;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
               DRIVE: begin
                  if (fall) begin
                     state                   <= IDLE;
                     d_oe                    <= 1'b0;
                     d_out                   <= '0;
                     {rom_en, ram_en, io_en} <= '0;
                  end else begin
                     d_oe  <= sel_oe;
                     d_out <= sel_oe ? sel_do : '0;
                  end
               end
               WHOLD: begin
                  if (fall) begin
                     state                   <= IDLE;
                     wr_data                 <= d_in;
                     ram_we                  <= sel == SEL_RAM;
                     io_we                   <= sel == SEL_IO;
                     {rom_en, ram_en, io_en} <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef YO6530_BUS_CONFLICT_DET_EN
   logic [2:0] oes;

   assign oes = {rom_oe, ram_oe, io_oe};

   // oes & (oes - 1) is non-zero exactly when more than one OE is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus_conflict <= 1'b0;
      else if ((oes & (oes - 3'd1)) != 3'd0 ||
               (state == DRIVE && (oes & ~{rom_en, ram_en, io_en}) != 3'd0))
         bus_conflict <= 1'b1;
   end
`endif

endmodule
